led_band_scan_sequencer: RTL and testbench
==========================================

LED_BAND_SCAN_SEQUENCER -- requirements
Module: led_band_scan_sequencer

Interface
REQ-001 SHALL have parameter NB_LED_COLUMN, default 32: LEDs (rows) per band.
REQ-002 SHALL have parameter BIT_PER_COLOR, default 8: stored grayscale bits per color.
REQ-003 SHALL have parameter NB_0_LSB, default 1: zero LSBs appended per color; GS_BITS = BIT_PER_COLOR+NB_0_LSB.
REQ-004 SHALL have parameter NB_ANGLES, default 128: angular slices per revolution.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: driver configured; no scan starts while low.
REQ-008 SHALL have port angle_tick, input, 1: one-clk strobe, start of next slice.
REQ-009 SHALL have port index, input, 1: level, revolution index mark sampled on angle_tick.
REQ-010 SHALL have port swap_req, input, 1: one-clk strobe, write buffer complete.
REQ-011 SHALL have ports SCLK and LAT, output, 1 each: driver shift clock and latch.
REQ-012 SHALL have ports angle, row, color and bit_sel, output, with widths clog2(NB_ANGLES), clog2(NB_LED_COLUMN), 2 and clog2(GS_BITS): read address fields.
REQ-013 SHALL have ports new_frame, busy and overrun, output, 1 each: buffer-swap pulse, scan in progress and sticky missed-tick flag.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT -> LATCH -> IDLE.
REQ-015 In IDLE, a pending tick with en=1 SHALL enter SHIFT on the next clk.
REQ-016 SCLK SHALL run at clk/2: phase 0 low, phase 1 high.
REQ-017 row, color and bit_sel SHALL update only in phase 0, one clk before the SCLK rise, to cover the 1-clk memory read latency.
REQ-018 Shift order SHALL be: row 0 to NB_LED_COLUMN-1; within a row, color 0,1,2; within a color, bit_sel GS_BITS-1 down to 0.
REQ-019 LAT SHALL be high during the final SCLK period of each row except the last (WRTGS).
REQ-020 LAT SHALL be high during the final 3 SCLK periods of the last row (LATGS).
REQ-021 After the last SCLK period, the FSM SHALL spend 2 clk in LATCH with SCLK=0 and LAT=0, then enter IDLE.
REQ-022 On an accepted tick, angle SHALL become 0 if index=1, else (angle+1) mod NB_ANGLES.
REQ-023 angle SHALL be held constant for the whole scan.
REQ-024 swap_req SHALL set a pending flag.
REQ-025 new_frame SHALL pulse for 1 clk on entry to SHIFT when the new angle is 0 and the flag is set; the flag SHALL clear in the same cycle.
REQ-026 A tick arriving while the FSM is not IDLE SHALL be held as one pending tick.
REQ-027 A second tick while one is already pending SHALL set overrun and be dropped.
REQ-028 If en falls mid-scan, the FSM SHALL finish the current scan and accept no new tick until en=1.
REQ-029 busy SHALL be 1 in SHIFT and LATCH.
REQ-030 If swap_req and angle_tick coincide, the swap SHALL be eligible for that same tick.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, with SCLK, LAT, new_frame, busy and overrun 0, row, color and bit_sel 0, angle NB_ANGLES-1, and pending tick and swap flags cleared.
REQ-032 Reset asserted mid-scan SHALL abort with no further LAT.

Configuration
REQ-033 With LED_SEQ_OVERRUN_CNT_EN defined, SHALL add output overrun_cnt, 16 bits: saturating count of dropped ticks, reset to 0.
REQ-034 Without LED_SEQ_OVERRUN_CNT_EN, the port and its counter SHALL be absent; overrun is unchanged.

Structure
REQ-035 Package led_band_pkg SHALL hold the FSM state enum, LATGS length constant 3 and a GS_BITS width helper.
REQ-036 One sub-module, led_band_bit_counter, SHALL hold the nested row/color/bit counters with a last-bit and last-row flag.

Verification (NB_LED_COLUMN=2, BIT_PER_COLOR=8, NB_0_LSB=1, NB_ANGLES=4: 54 SCLK periods, 108 clk per scan)
REQ-037 Single tick, en=1: SHALL give 54 SCLK rises, bit_sel 8..0 repeated per color, LAT high at period 27 and periods 52-54, then busy=0 at clk 110.
REQ-038 Ticks with index=0,0,0,0 from reset: angle SHALL read 0,1,2,3; a following tick with index=1 SHALL give 0.
REQ-039 swap_req at angle 2, then ticks: new_frame SHALL pulse once, on the scan start with angle 0.
REQ-040 Three ticks within one scan: one SHALL be queued and executed, with overrun=1 (overrun_cnt=1 when the macro is defined).
REQ-041 rst=0 at clk 40 of a scan: outputs SHALL reach reset values immediately, with no LAT afterward.
REQ-042 en=0 with a tick: no SCLK; the tick SHALL remain pending and the scan SHALL start 1 clk after en rises.

Source files
------------

// File: rtl/led_band_pkg.sv
// Shared types and constants for the LED band scan sequencer.
package led_band_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } scan_state_t;

   // Number of closing SCLK periods of the last row that carry LAT (LATGS).
   localparam int LATGS_LEN  = 3;
   localparam int LATCH_CLKS = 2;

   function automatic int gs_bits(input int bit_per_color, input int nb_0_lsb);
      return bit_per_color + nb_0_lsb;
   endfunction

endpackage

// File: rtl/led_band_bit_counter.sv
// Nested row / color / grayscale-bit address counters for one band scan.
module led_band_bit_counter #(
   parameter int NB_LED_COLUMN = 32,
   parameter int GS_BITS       = 9,
   parameter int RW            = $clog2(NB_LED_COLUMN),
   parameter int BW            = $clog2(GS_BITS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic          clear,
   output logic [RW-1:0] row,
   output logic [1:0]    color,
   output logic [BW-1:0] bit_sel,
   output logic          last_bit,
   output logic          last_row
);

   assign last_bit = (color == 2'd2) && (bit_sel == '0);
   assign last_row = (row == RW'(NB_LED_COLUMN - 1));

   // Bits count down (MSB first), then colors, then rows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row     <= '0;
         color   <= '0;
         bit_sel <= '0;
      end else if (clear) begin
         row     <= '0;
         color   <= '0;
         bit_sel <= '0;
      end else if (load) begin
         row     <= '0;
         color   <= '0;
         bit_sel <= BW'(GS_BITS - 1);
      end else if (step) begin
         if (bit_sel != '0) begin
            bit_sel <= bit_sel - BW'(1);
         end else begin
            bit_sel <= BW'(GS_BITS - 1);
            if (color != 2'd2) begin
               color <= color + 2'd1;
            end else begin
               color <= 2'd0;
               row   <= row + RW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/led_band_scan_sequencer.sv
// Per-slice scan sequencer for a rotating LED band driver (SCLK/LAT plus read address).
// Optional LED_SEQ_OVERRUN_CNT_EN adds a saturating 16-bit dropped-tick counter output.
module led_band_scan_sequencer
   import led_band_pkg::*;
#(
   parameter int NB_LED_COLUMN = 32,
   parameter int BIT_PER_COLOR = 8,
   parameter int NB_0_LSB      = 1,
   parameter int NB_ANGLES     = 128,
   localparam int GS_BITS      = gs_bits(BIT_PER_COLOR, NB_0_LSB),
   localparam int AW           = $clog2(NB_ANGLES),
   localparam int RW           = $clog2(NB_LED_COLUMN),
   localparam int BW           = $clog2(GS_BITS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          angle_tick,
   input  logic          index,
   input  logic          swap_req,
   output logic          SCLK,
   output logic          LAT,
   output logic [AW-1:0] angle,
   output logic [RW-1:0] row,
   output logic [1:0]    color,
   output logic [BW-1:0] bit_sel,
   output logic          new_frame,
   output logic          busy,
   output logic          overrun,
   output logic [1:0]    state_dbg
`ifdef LED_SEQ_OVERRUN_CNT_EN
   ,
   output logic [15:0]   overrun_cnt
`endif
);

   // Handshake: angle_tick and swap_req are one-clk strobes with no back-pressure;
   // a tick is consumed when the FSM is IDLE with en=1, otherwise it waits in a
   // single-entry pending slot and any further tick is dropped and flagged.

   scan_state_t state, state_nxt;
   logic        phase;
   logic        lat_cnt;
   logic        tick_pend, tick_pend_idx, swap_pend;
   logic        start, use_idx, swap_now, tick_drop, in_latgs;
   logic        cnt_load, cnt_step, cnt_clear;
   logic        last_bit, last_row;
   logic [AW-1:0] angle_nxt;

   assign state_dbg = state;
   assign start     = (state == ST_IDLE) && en && (tick_pend || angle_tick);
   assign use_idx   = tick_pend ? tick_pend_idx : index;
   assign angle_nxt = (use_idx || (angle == AW'(NB_ANGLES - 1))) ? '0 : angle + AW'(1);
   assign swap_now  = swap_pend || swap_req;
   assign tick_drop = !start && angle_tick && tick_pend;
   assign in_latgs  = last_row && (color == 2'd2) && (bit_sel < BW'(LATGS_LEN));

   led_band_bit_counter #(
      .NB_LED_COLUMN (NB_LED_COLUMN),
      .GS_BITS       (GS_BITS),
      .RW            (RW),
      .BW            (BW)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .step     (cnt_step),
      .clear    (cnt_clear),
      .row      (row),
      .color    (color),
      .bit_sel  (bit_sel),
      .last_bit (last_bit),
      .last_row (last_row)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Counters advance at the end of the SCLK-high phase so the new address is
   // presented a full clk before the next rise.
   always_comb begin
      state_nxt = state;
      SCLK      = 1'b0;
      LAT       = 1'b0;
      busy      = 1'b0;
      cnt_load  = 1'b0;
      cnt_step  = 1'b0;
      cnt_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SHIFT;
               cnt_load  = 1'b1;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            SCLK = phase;
            LAT  = (last_bit && !last_row) || in_latgs;
            if (phase) begin
               if (last_bit && last_row) begin
                  cnt_clear = 1'b1;
                  state_nxt = ST_LATCH;
               end else begin
                  cnt_step = 1'b1;
               end
            end
         end
         ST_LATCH: begin
            busy = 1'b1;
            if (lat_cnt == 1'(LATCH_CLKS - 1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase         <= 1'b0;
         lat_cnt       <= 1'b0;
         angle         <= AW'(NB_ANGLES - 1);
         tick_pend     <= 1'b0;
         tick_pend_idx <= 1'b0;
         swap_pend     <= 1'b0;
         new_frame     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         phase     <= (state == ST_SHIFT) ? ~phase : 1'b0;
         lat_cnt   <= (state == ST_LATCH) ? lat_cnt + 1'b1 : 1'b0;
         new_frame <= 1'b0;
         if (start) begin
            angle         <= angle_nxt;
            new_frame     <= (angle_nxt == '0) && swap_now;
            swap_pend     <= swap_now && (angle_nxt != '0);
            // A fresh tick alongside a consumed pending one takes the freed slot.
            tick_pend     <= tick_pend && angle_tick;
            tick_pend_idx <= index;
         end else begin
            if (swap_req) swap_pend <= 1'b1;
            if (angle_tick) begin
               if (tick_pend) begin
                  overrun <= 1'b1;
               end else begin
                  tick_pend     <= 1'b1;
                  tick_pend_idx <= index;
               end
            end
         end
      end
   end

`ifdef LED_SEQ_OVERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  overrun_cnt <= '0;
      else if (tick_drop && overrun_cnt != '1)   overrun_cnt <= overrun_cnt + 16'd1;
   end
`else
   logic unused_drop;
   assign unused_drop = tick_drop;
`endif

endmodule

// File: tb/tb_led_band_scan_sequencer.sv
// Scoreboard bench for led_band_scan_sequencer (2 rows, 9 GS bits, 4 angles).
module tb_led_band_scan_sequencer;

  localparam int NB_COL    = 2;
  localparam int GS        = 9;
  localparam int NA        = 4;
  localparam int PERIODS   = NB_COL * 3 * GS;
  localparam int SCAN_CLKS = 2 * PERIODS + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, angle_tick = 1'b0, index = 1'b0, swap_req = 1'b0;
  logic sclk, lat, new_frame, busy, overrun;
  logic [1:0] angle, color, state_dbg;
  logic [0:0] row;
  logic [3:0] bit_sel;
`ifdef LED_SEQ_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic [2:0] scan_q[$];

  int m_angle = NA - 1;
  int m_busy_left = 0;
  int m_cnt = 0;
  bit m_pend = 0, m_pend_idx = 0, m_swap = 0, m_ovr = 0;

  led_band_scan_sequencer #(
    .NB_LED_COLUMN (NB_COL),
    .BIT_PER_COLOR (8),
    .NB_0_LSB      (1),
    .NB_ANGLES     (NA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .angle_tick (angle_tick),
    .index      (index),
    .swap_req   (swap_req),
    .SCLK       (sclk),
    .LAT        (lat),
    .angle      (angle),
    .row        (row),
    .color      (color),
    .bit_sel    (bit_sel),
    .new_frame  (new_frame),
    .busy       (busy),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
`ifdef LED_SEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one scan = fixed number of clocks, expected periods listed per scan
  always @(posedge clk) begin
    if (!rst) begin
      m_angle = NA - 1; m_busy_left = 0; m_cnt = 0;
      m_pend = 0; m_pend_idx = 0; m_swap = 0; m_ovr = 0;
      exp_q.delete();
      scan_q.delete();
    end else if (m_busy_left == 0 && en && (m_pend || angle_tick)) begin
      bit idx, nf, swap_now, l;
      int a;
      idx = m_pend ? m_pend_idx : index;
      swap_now = m_swap || swap_req;
      a = idx ? 0 : (m_angle + 1) % NA;
      nf = (a == 0) && swap_now;
      scan_q.push_back({2'(a), nf});
      for (int r = 0; r < NB_COL; r++)
        for (int c = 0; c < 3; c++)
          for (int b = GS - 1; b >= 0; b--) begin
            l = (r == NB_COL - 1) ? (c == 2 && b < 3) : (c == 2 && b == 0);
            exp_q.push_back({2'(a), 1'(r), 2'(c), 4'(b), l});
          end
      m_angle = a;
      m_swap = swap_now && !nf;
      if (m_pend && angle_tick) begin
        m_pend = 1; m_pend_idx = index;
      end else begin
        m_pend = 0;
      end
      m_busy_left = SCAN_CLKS;
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (swap_req) m_swap = 1;
      if (angle_tick) begin
        if (m_pend) begin
          m_ovr = 1;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_pend = 1; m_pend_idx = index;
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT starts a scan or raises SCLK
  logic prev_sclk = 0, prev_busy = 0, prev_lat = 0;
  logic [6:0] prev_addr = '0;
  logic [1:0] scan_angle = '0;
  int busy_cnt = 0, rise_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("busy", busy, m_busy_left > 0);
      chk("overrun", overrun, m_ovr);
`ifdef LED_SEQ_OVERRUN_CNT_EN
      chk("overrun_cnt", overrun_cnt, m_cnt);
`endif
      if (busy && !prev_busy) begin
        busy_cnt = 0;
        rise_cnt = 0;
        if (scan_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scan_start: got unexpected scan, required none at %0t", $time);
        end else begin
          logic [2:0] e;
          e = scan_q.pop_front();
          scan_angle = e[2:1];
          chk("scan_start{angle,new_frame}", {angle, new_frame}, e);
        end
      end else begin
        chk("new_frame_quiet", new_frame, 0);
      end
      if (busy) begin
        busy_cnt++;
        chk("angle_hold", angle, scan_angle);
      end
      if (!busy && prev_busy) begin
        chk("busy_len", busy_cnt, SCAN_CLKS);
        chk("sclk_rises", rise_cnt, PERIODS);
      end
      if (sclk && !prev_sclk) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sclk_period: got unexpected SCLK rise, required none at %0t", $time);
        end else begin
          chk("period{angle,row,color,bit,lat}", {angle, row, color, bit_sel, lat}, exp_q.pop_front());
        end
      end
      if (sclk) begin
        chk("addr_stable", {row, color, bit_sel}, prev_addr);
        chk("lat_stable", lat, prev_lat);
      end
      if (!busy) chk("idle_quiet{sclk,lat}", {sclk, lat}, 0);
      prev_sclk = sclk;
      prev_busy = busy;
      prev_lat  = lat;
      prev_addr = {row, color, bit_sel};
    end else begin
      prev_sclk = 0;
      prev_busy = 0;
      prev_lat  = 0;
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit tick, input bit idx, input bit swap);
    angle_tick = tick;
    index = idx;
    swap_req = swap;
    cycles(1);
    angle_tick = 0;
    swap_req = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (m_busy_left == 0 && !m_pend && !busy) done = 1;
      else cycles(1);
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy after 2000 clk, required idle");
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sclk"}, sclk, 0);
    chk({tag, "_lat"}, lat, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_new_frame"}, new_frame, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_angle"}, angle, NA - 1);
    chk({tag, "_addr"}, {row, color, bit_sel}, 0);
    chk({tag, "_state"}, state_dbg, 0);
`ifdef LED_SEQ_OVERRUN_CNT_EN
    chk({tag, "_overrun_cnt"}, overrun_cnt, 0);
`endif
  endtask

  initial begin
    cycles(2);
    check_reset_values("reset");
    rst = 1;
    en = 1;
    cycles(2);

    // single scan, then angle stepping with a swap requested at angle 2
    drive(1, 0, 0); wait_idle();
    drive(1, 0, 0); wait_idle();
    drive(1, 0, 0); wait_idle();
    drive(0, 0, 1); cycles(3);
    drive(1, 0, 0); wait_idle();
    drive(1, 0, 0); wait_idle();
    drive(1, 1, 0); wait_idle();

    // swap coinciding with an index tick
    drive(1, 1, 1); wait_idle();

    // three ticks in one scan: one queued, one dropped
    drive(1, 0, 0); cycles(10);
    drive(1, 0, 0); cycles(10);
    drive(1, 1, 0); wait_idle();

    // tick held while disabled, scan starts one clk after enable
    en = 0;
    drive(1, 0, 0);
    cycles(20);
    chk("disabled_busy", busy, 0);
    chk("disabled_sclk", sclk, 0);
    en = 1;
    cycles(1);
    chk("enable_start_busy", busy, 1);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 15) != 0);
      angle_tick = ($urandom_range(0, 79) == 0);
      index = ($urandom_range(0, 3) == 0);
      swap_req = ($urandom_range(0, 49) == 0);
      cycles(1);
    end
    angle_tick = 0;
    swap_req = 0;
    en = 1;
    wait_idle();

    // asynchronous reset in the middle of a scan
    drive(1, 0, 0);
    cycles(39);
    #2;
    rst = 0;
    #1;
    check_reset_values("midscan_reset");
    cycles(2);
    rst = 1;
    cycles(150);
    drive(1, 0, 0); wait_idle();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("scan_q_empty", scan_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
